// File: rtl/config_pkg.sv
// Shared constants, state types and helpers for the AXI4-Lite config bridge.
package config_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        COLLECT,
        ISSUE,
        RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_e;

    function automatic int byte_shift(input int data_bits);
        return $clog2(data_bits / 8);
    endfunction

endpackage

// File: rtl/config_if.sv
// Config write stream: one-cycle valid pulses carrying a word address and data.
interface config_i #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 64
);
    logic                 valid;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;

    modport m (output valid, output addr, output data);
    modport s (input valid, input addr, input data);
endinterface

// File: rtl/config_axil_hold.sv
// Single-entry valid/ready capture register with clear.
module config_axil_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d,
    output logic             d_ready,
    output logic             held,
    output logic [WIDTH-1:0] q
);

    assign d_ready = en && !held;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held <= 1'b0;
            q    <= '0;
        end else if (clr) begin
            held <= 1'b0;
        end else if (d_valid && d_ready) begin
            held <= 1'b1;
            q    <= d;
        end
    end

endmodule

// File: rtl/config_axil_bridge.sv
// AXI4-Lite slave turning host writes into config write pulses; reads get SLVERR.
// Define CONFIG_AXIL_WSTRB_CHECK_EN to reject writes with partial strobes.
module config_axil_bridge
    import config_pkg::*;
#(
    parameter int AXIL_ADDR_BITS  = 16,
    parameter int DATA_BITS       = 64,
    parameter int ADDR_SPACE_SIZE = 256,
    parameter int CFG_ADDR_BITS   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXIL_ADDR_BITS-1:0] s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DATA_BITS-1:0]      s_wdata,
    input  logic [DATA_BITS/8-1:0]    s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic [AXIL_ADDR_BITS-1:0] s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [DATA_BITS-1:0]      s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    config_i.m                        out
);

    localparam int SHIFT     = byte_shift(DATA_BITS);
    localparam int STRB_BITS = DATA_BITS / 8;
    localparam int W_BITS    = DATA_BITS + STRB_BITS;

    wr_state_e wstate;
    rd_state_e rstate;
    logic      live;
    logic      collect;
    logic      clr;
    logic      aw_held;
    logic      w_held;
    logic      aw_full;
    logic      w_full;
    logic      in_range;
    logic      strb_ok;
    logic      accept;

    logic [AXIL_ADDR_BITS-1:0] aw_q;
    logic [AXIL_ADDR_BITS-1:0] awaddr_n;
    logic [AXIL_ADDR_BITS-1:0] waddr;
    logic [W_BITS-1:0]         w_q;
    logic [W_BITS-1:0]         w_n;

    logic                     cfg_valid_q;
    logic [CFG_ADDR_BITS-1:0] cfg_addr_q;
    logic [DATA_BITS-1:0]     cfg_data_q;
    logic                     bvalid_q;
    logic [1:0]               bresp_q;
    logic                     arready_q;
    logic                     rvalid_q;
    logic [1:0]               rresp_q;

    assign collect = live && (wstate == COLLECT);
    assign clr     = (wstate == RESP) && s_bready;

    config_axil_hold #(.WIDTH(AXIL_ADDR_BITS)) u_aw_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .en      (collect),
        .d_valid (s_awvalid),
        .d       (s_awaddr),
        .d_ready (s_awready),
        .held    (aw_held),
        .q       (aw_q)
    );

    config_axil_hold #(.WIDTH(W_BITS)) u_w_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .en      (collect),
        .d_valid (s_wvalid),
        .d       ({s_wstrb, s_wdata}),
        .d_ready (s_wready),
        .held    (w_held),
        .q       (w_q)
    );

    // Issue in the cycle right after the second beat lands, so bypass the holds.
    assign aw_full  = aw_held || (s_awvalid && s_awready);
    assign w_full   = w_held || (s_wvalid && s_wready);
    assign awaddr_n = aw_held ? aw_q : s_awaddr;
    assign w_n      = w_held ? w_q : {s_wstrb, s_wdata};
    assign waddr    = awaddr_n >> SHIFT;
    assign in_range = 32'(waddr) < 32'(ADDR_SPACE_SIZE);

`ifdef CONFIG_AXIL_WSTRB_CHECK_EN
    logic unused_bits;
    assign strb_ok     = &w_n[DATA_BITS +: STRB_BITS];
    assign unused_bits = ^s_araddr;
`else
    logic unused_bits;
    assign strb_ok     = 1'b1;
    assign unused_bits = ^{s_araddr, w_n[DATA_BITS +: STRB_BITS]};
`endif

    assign accept = in_range && strb_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wstate      <= COLLECT;
            live        <= 1'b0;
            cfg_valid_q <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
        end else begin
            live        <= 1'b1;
            cfg_valid_q <= 1'b0;
            unique case (wstate)
                COLLECT: begin
                    if (live && aw_full && w_full) begin
                        wstate      <= ISSUE;
                        cfg_valid_q <= accept;
                        cfg_addr_q  <= CFG_ADDR_BITS'(waddr);
                        cfg_data_q  <= w_n[DATA_BITS-1:0];
                        bresp_q     <= accept ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                ISSUE: begin
                    wstate   <= RESP;
                    bvalid_q <= 1'b1;
                end
                RESP: begin
                    if (s_bready) begin
                        wstate   <= COLLECT;
                        bvalid_q <= 1'b0;
                    end
                end
                default: wstate <= COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rstate    <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (s_arvalid && arready_q) begin
                        rstate    <= R_RESP;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rresp_q   <= RESP_SLVERR;
                    end
                end
                R_RESP: begin
                    if (s_rready) begin
                        rstate    <= R_IDLE;
                        arready_q <= 1'b1;
                        rvalid_q  <= 1'b0;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    // A pulse already registered must not escape during the reset cycle.
    assign out.valid = cfg_valid_q && rst_n;
    assign out.addr  = cfg_addr_q;
    assign out.data  = cfg_data_q;

    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = '0;

endmodule
